serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//   Sequences one 1-bit full_adder cell to perform a WIDTH-bit addition bit-serially, LSB first.
//   Trades WIDTH cycles of latency for a single adder cell.
//   Sits between an operand producer and a result consumer.
//   Uses a valid/ready handshake on both sides.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range WIDTH >= 2
// PORTS
//   clk        in   1      single clock, all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand set a/b/cin is valid
//   in_ready   out  1      block can accept operands (IDLE only)
//   a          in   WIDTH  operand A, sampled only on input handshake
//   b          in   WIDTH  operand B, sampled only on input handshake
//   cin        in   1      carry-in, sampled only on input handshake
//   out_valid  out  1      sum/cout hold a completed result
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  a + b + cin, modulo 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//   Reset values:
//     - state = IDLE, in_ready = 1, out_valid = 0, sum = 0, cout = 0.
//     - Shift registers, carry flop and counter are all 0.
//   FSM states: IDLE, RUN, DONE.
//   IDLE:
//     - in_ready = 1.
//     - On in_valid & in_ready: load a_sr <= a, b_sr <= b, c_q <= cin, cnt <= 0, go to RUN.
//   RUN (in_ready = 0):
//     - Each cycle, the cell computes (s, co) = fa(a_sr[0], b_sr[0], c_q).
//     - Updates: sum_sr <= {s, sum_sr[WIDTH-1:1]}, a_sr >>= 1, b_sr >>= 1, c_q <= co, cnt++.
//     - On the cycle with cnt == WIDTH-1: go to DONE.
//   DONE:
//     - out_valid = 1; sum = sum_sr, cout = c_q.
//     - Outputs are held stable until out_ready = 1, then go to IDLE.
//   Latency and throughput:
//     - Input handshake at edge k -> out_valid high after edge k+WIDTH.
//     - Minimum of one op per WIDTH+2 cycles; no overlap between ops.
//   Ignored inputs:
//     - a, b, cin and in_valid are ignored outside the IDLE handshake.
//     - out_ready is ignored outside DONE.
//   sum/cout are registered; they keep their last value after the output handshake until the next DONE.
//   Counter width is $clog2(WIDTH). The counter never wraps: it is cleared on load and used only in RUN.
//   rst asserted in any state (including mid-RUN): on the next edge, all values return to reset.
//     The partial result is discarded and no out_valid is produced for it.
//   in_valid and rst high together: reset wins; operands are not captured.
// STRUCTURE
//   Shared package serial_add_pkg holds:
//     - the state enum: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
//     - the default WIDTH constant.
//   Exactly one sub-module: a single instance of the team's existing full_adder cell.
//     Ports a, b, c, sum, carry map to a_sr[0], b_sr[0], c_q, s, co.
//   Everything else (FSM, counter, shift registers, carry flop) is inline in this module.
// TESTING
//   1. WIDTH=8, a=0x5A, b=0x3C, cin=0, out_ready=1
//      -> sum=0x96, cout=0; out_valid rises exactly 8 cycles after the accept edge.
//   2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
//      a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
//   3. Backpressure: hold out_ready=0 for 5 cycles in DONE
//      -> sum/cout/out_valid stable and in_ready=0.
//      in_valid held high with a=0x11 during this time -> not captured.
//   4. Reset mid-op: assert rst during RUN at cnt=3
//      -> next cycle in_ready=1, out_valid=0, sum=0, cout=0.
//      A new op a=0x01, b=0x02 then yields sum=0x03.
//   5. Back-to-back: in_valid held high across two ops
//      -> second accept happens in the IDLE cycle after the output handshake; both results are correct.
//   6. 1000 random a/b/cin with random out_ready stalls, WIDTH=8 and WIDTH=13
//      -> {cout, sum} == a + b + cin for every result.

Source files
------------

// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_pkg
// Brief    : Shared types and constants for the bit-serial adder controller.
//            Holds the controller state encoding and the default datapath
//            width.
// Revision : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    // Controller states; encodings are fixed so they stay stable in traces.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default operand/result width.
    localparam int c_default_width = 8;

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder
// Brief    : Single-bit full adder cell (purely combinational).
//   a, b   : in  1  addend bits
//   c      : in  1  carry in
//   sum    : out 1  a ^ b ^ c
//   carry  : out 1  majority(a, b, c)
// Revision : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Brief    : Bit-serial WIDTH-bit adder. One full_adder cell is stepped
//            LSB first over WIDTH cycles. Valid/ready handshake on both the
//            operand side and the result side; no overlap between ops.
//   clk       : in  1      clock, rising edge
//   rst       : in  1      synchronous active-high reset
//   in_valid  : in  1      operands a/b/cin valid
//   in_ready  : out 1      block can accept operands (IDLE only)
//   a, b      : in  WIDTH  operands, sampled on input handshake
//   cin       : in  1      carry in, sampled on input handshake
//   out_valid : out 1      sum/cout hold a completed result
//   out_ready : in  1      consumer accepts result
//   sum       : out WIDTH  a + b + cin mod 2^WIDTH
//   cout      : out 1      carry out of bit WIDTH-1
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                 c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_sum_sr;
    logic               r_c_q;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum_hold;
    logic               r_cout_hold;

    logic               w_s;
    logic               w_co;
    logic               w_accept;
    logic               w_release;

    full_adder u_fa (
        .a     (r_a_sr[0]),
        .b     (r_b_sr[0]),
        .c     (r_c_q),
        .sum   (w_s),
        .carry (w_co)
    );

    assign w_accept  = in_valid  && (r_state == IDLE);
    assign w_release = out_ready && (r_state == DONE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)         w_state_nxt = RUN;
            RUN:     if (r_cnt == c_last)  w_state_nxt = DONE;
            DONE:    if (out_ready)        w_state_nxt = IDLE;
            default:                       w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand/result shift registers, carry flop, bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_sum_sr    <= '0;
            r_c_q       <= 1'b0;
            r_cnt       <= '0;
            r_sum_hold  <= '0;
            r_cout_hold <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_sr <= a;
                r_b_sr <= b;
                r_c_q  <= cin;
                r_cnt  <= '0;
            end else if (r_state == RUN) begin
                // Result bits enter at the MSB so after WIDTH steps bit 0
                // of the sum has landed in position 0.
                r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
                r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
                r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
                r_c_q    <= w_co;
                r_cnt    <= r_cnt + c_cnt_w'(1);
            end

            // The shift registers are reused by the next op, so the
            // delivered result is copied aside when the consumer takes it.
            if (w_release) begin
                r_sum_hold  <= r_sum_sr;
                r_cout_hold <= r_c_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = (r_state == DONE) ? r_sum_sr : r_sum_hold;
    assign cout      = (r_state == DONE) ? r_c_q    : r_cout_hold;

endmodule : serial_add_ctrl
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Brief    : Directed and random self-checking bench for serial_add_ctrl,
//            with one 8-bit and one 13-bit instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0, cin8 = 1'b0, cout8;
    logic [7:0]  a8 = '0, b8 = '0, sum8;

    logic        iv13 = 1'b0, ir13, ov13, or13 = 1'b0, cin13 = 1'b0, cout13;
    logic [12:0] a13 = '0, b13 = '0, sum13;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(13)) u_dut13 (
        .clk(clk), .rst(rst), .in_valid(iv13), .in_ready(ir13), .a(a13), .b(b13),
        .cin(cin13), .out_valid(ov13), .out_ready(or13), .sum(sum13), .cout(cout13)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full op on the 8-bit instance: present operands, wait for accept,
    // wait for out_valid, stall 'stall' cycles, then take the result.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input int stall, output logic [7:0] rs, output logic rc,
                        output int lat);
        int t = 0;
        a8 = ta; b8 = tb; cin8 = tc; iv8 = 1'b1;
        while (!ir8 && t < 50) begin tick(); t++; end
        if (t >= 50) check("run8_accept_timeout", 64'd1, 64'd0);
        tick();
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 50) begin tick(); lat++; end
        if (lat >= 50) check("run8_valid_timeout", 64'd1, 64'd0);
        repeat (stall) tick();
        rs = sum8; rc = cout8;
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
    endtask

    task automatic run13(input logic [12:0] ta, input logic [12:0] tb, input logic tc,
                         input int stall, output logic [12:0] rs, output logic rc);
        int t = 0;
        a13 = ta; b13 = tb; cin13 = tc; iv13 = 1'b1;
        while (!ir13 && t < 50) begin tick(); t++; end
        if (t >= 50) check("run13_accept_timeout", 64'd1, 64'd0);
        tick();
        iv13 = 1'b0;
        t = 0;
        while (!ov13 && t < 50) begin tick(); t++; end
        if (t >= 50) check("run13_valid_timeout", 64'd1, 64'd0);
        repeat (stall) tick();
        rs = sum13; rc = cout13;
        or13 = 1'b1;
        tick();
        or13 = 1'b0;
    endtask

    initial begin : main
        logic [7:0]  s8;
        logic [12:0] s13;
        logic        c;
        int          lat;
        logic [7:0]  ra8, rb8;
        logic [12:0] ra13, rb13;
        logic        rc;
        logic [13:0] exp13;
        logic [8:0]  exp8;
        logic        saw_ov;

        // ---------------- reset ----------------
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_in_ready",  64'(ir8),   64'd1);
        check("rst_out_valid", 64'(ov8),   64'd0);
        check("rst_sum",       64'(sum8),  64'd0);
        check("rst_cout",      64'(cout8), 64'd0);
        check("rst_in_ready13", 64'(ir13), 64'd1);

        // ---------------- 1: basic add + latency ----------------
        run8(8'h5A, 8'h3C, 1'b0, 0, s8, c, lat);
        check("t1_sum",     64'(s8),  64'h96);
        check("t1_cout",    64'(c),   64'd0);
        check("t1_latency", 64'(lat), 64'd8);
        check("t1_sum_held_idle", 64'(sum8), 64'h96);

        // ---------------- 2: carry boundaries ----------------
        run8(8'hFF, 8'h01, 1'b0, 0, s8, c, lat);
        check("t2a_sum",  64'(s8), 64'h00);
        check("t2a_cout", 64'(c),  64'd1);
        run8(8'hFF, 8'hFF, 1'b1, 1, s8, c, lat);
        check("t2b_sum",  64'(s8), 64'hFF);
        check("t2b_cout", 64'(c),  64'd1);

        // ---------------- 3: backpressure ----------------
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; iv8 = 1'b1;
        tick();                         // accepted
        a8 = 8'h11; b8 = 8'h00; cin8 = 1'b0;  // must not be captured
        begin
            int t = 0;
            while (!ov8 && t < 50) begin tick(); t++; end
        end
        for (int i = 0; i < 5; i++) begin
            check("t3_sum_stable",  64'(sum8),  64'h47);
            check("t3_cout_stable", 64'(cout8), 64'd0);
            check("t3_valid_held",  64'(ov8),   64'd1);
            check("t3_in_ready_lo", 64'(ir8),   64'd0);
            tick();
        end
        or8 = 1'b1; iv8 = 1'b0;
        tick();
        or8 = 1'b0;
        check("t3_idle_in_ready", 64'(ir8),  64'd1);
        check("t3_idle_no_valid", 64'(ov8),  64'd0);
        check("t3_sum_kept",      64'(sum8), 64'h47);

        // ---------------- 4: reset mid-RUN ----------------
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; iv8 = 1'b1;
        tick();                         // accepted, cnt = 0
        iv8 = 1'b0;
        repeat (3) tick();              // cnt = 3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_in_ready",  64'(ir8),   64'd1);
        check("t4_out_valid", 64'(ov8),   64'd0);
        check("t4_sum",       64'(sum8),  64'd0);
        check("t4_cout",      64'(cout8), 64'd0);
        saw_ov = 1'b0;
        repeat (12) begin tick(); if (ov8) saw_ov = 1'b1; end
        check("t4_no_stale_valid", 64'(saw_ov), 64'd0);
        run8(8'h01, 8'h02, 1'b0, 0, s8, c, lat);
        check("t4_new_sum",  64'(s8), 64'h03);
        check("t4_new_cout", 64'(c),  64'd0);

        // ---------------- 5: back-to-back with in_valid held ----------------
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; iv8 = 1'b1;
        tick();                         // first op accepted
        check("t5_busy", 64'(ir8), 64'd0);
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b1;
        begin
            int t = 0;
            while (!ov8 && t < 50) begin tick(); t++; end
        end
        check("t5_op1_sum",  64'(sum8),  64'h00);
        check("t5_op1_cout", 64'(cout8), 64'd1);
        or8 = 1'b1;
        tick();                         // output handshake -> IDLE
        or8 = 1'b0;
        check("t5_idle_gap", 64'(ir8), 64'd1);
        tick();                         // second op accepted here
        check("t5_op2_accepted", 64'(ir8), 64'd0);
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 50) begin tick(); lat++; end
        check("t5_op2_latency", 64'(lat),   64'd8);
        check("t5_op2_sum",     64'(sum8),  64'h11);
        check("t5_op2_cout",    64'(cout8), 64'd0);
        or8 = 1'b1;
        tick();
        or8 = 1'b0;

        // ---------------- 6: random, WIDTH=8 and WIDTH=13 ----------------
        for (int i = 0; i < 1000; i++) begin
            ra8 = 8'($urandom_range(0, 255));
            rb8 = 8'($urandom_range(0, 255));
            rc  = 1'($urandom_range(0, 1));
            run8(ra8, rb8, rc, int'($urandom_range(0, 3)), s8, c, lat);
            exp8 = {1'b0, ra8} + {1'b0, rb8} + {8'd0, rc};
            check("rand8", 64'({c, s8}), 64'(exp8));
        end
        for (int i = 0; i < 1000; i++) begin
            ra13 = 13'($urandom_range(0, 8191));
            rb13 = 13'($urandom_range(0, 8191));
            rc   = 1'($urandom_range(0, 1));
            run13(ra13, rb13, rc, int'($urandom_range(0, 3)), s13, c);
            exp13 = {1'b0, ra13} + {1'b0, rb13} + {13'd0, rc};
            check("rand13", 64'({c, s13}), 64'(exp13));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_add_ctrl
`default_nettype wire
